dmem_arb: RTL

- Two-port arbiter and sequencer in front of the data memory.
- Port 0 is the core load/store unit; port 1 is the auxiliary master (debug/DMA loader).
- Selects one request per cycle with round-robin priority, drives the memory write controls, and registers read data into a per-port response with valid/ready backpressure.
- Sits between the pipeline MEM stage and dmem. dmem reads combinationally and writes on the rising edge.

---
 rtl/dmem_arb_pkg.sv | 60 ++++++
 rtl/dmem_arb_rr_arb2.sv | 36 +++
 rtl/dmem_arb.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the data-memory arbiter and its round-robin core.
// The request error helper is only referenced when DMEM_ARB_ADDR_CHK_EN is defined.
package dmem_arb_pkg;

  localparam int XLEN            = 32;
  localparam int BYTE_WIDTH      = 8;
  localparam int DMEM_MEM_SIZE   = 1024;
  localparam int DMEM_ARB_N_REQ  = 2;
  localparam int STRB_W          = XLEN / BYTE_WIDTH;
  localparam int DMEM_ADDR_LIMIT = DMEM_MEM_SIZE * STRB_W;
  localparam int CHK_W           = XLEN + 1;

  typedef enum logic {
    RR_PORT0 = 1'b0,
    RR_PORT1 = 1'b1
  } rr_port_e;

  typedef struct packed {
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [STRB_W-1:0] wstrb;
  } dmem_req_t;

  typedef struct packed {
    logic [XLEN-1:0] rdata;
    logic            err;
  } dmem_resp_t;

  // Out of range, or the first strobed byte not aligned to the access size.
  function automatic logic req_err(input dmem_req_t r, input int unsigned limit);
    logic [CHK_W-1:0] end_addr;
    logic [2:0]       cnt;
    logic [1:0]       low;
    logic             found;
    logic [2:0]       ofs;
    logic             mis;
    end_addr = {1'b0, r.addr} + CHK_W'(STRB_W);
    cnt      = '0;
    low      = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      if (r.wstrb[i]) begin
        cnt = cnt + 3'd1;
        if (!found) begin
          low   = 2'(i);
          found = 1'b1;
        end
      end
    end
    ofs = {1'b0, r.addr[1:0]} + {1'b0, low};
    if (r.we) begin
      mis = (cnt != 3'd0) && ((ofs % cnt) != 3'd0);
    end else begin
      mis = (r.addr[1:0] != 2'b00);
    end
    return (end_addr > CHK_W'(limit)) || mis;
  endfunction

endpackage

// File: rtl/dmem_arb_rr_arb2.sv
// Two-input round-robin arbiter: on contention the port that did not win last gets the grant.
// last_grant only moves when a grant is actually taken.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_gnt
);

  rr_port_e last_grant_q, last_grant_d;

  always_comb begin
    o_gnt        = 2'b00;
    last_grant_d = last_grant_q;
    if (i_req == 2'b11) begin
      o_gnt = (last_grant_q == RR_PORT1) ? 2'b01 : 2'b10;
    end else begin
      o_gnt = i_req;
    end
    if (i_advance && (o_gnt != 2'b00)) begin
      last_grant_d = o_gnt[1] ? RR_PORT1 : RR_PORT0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_grant_q <= RR_PORT1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/dmem_arb.sv
// Two-port round-robin arbiter/sequencer in front of dmem with registered per-port responses.
// Define DMEM_ARB_ADDR_CHK_EN to flag out-of-range or misaligned requests via o_resp_err.
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int N_REQ      = DMEM_ARB_N_REQ,
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_LIMIT = DMEM_ADDR_LIMIT
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic [N_REQ-1:0]                         i_req_valid,
  output logic [N_REQ-1:0]                         o_req_ready,
  input  logic [N_REQ-1:0]                         i_req_we,
  input  logic [N_REQ*XLEN-1:0]                    i_req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]              i_req_wdata,
  input  logic [N_REQ*(DATA_WIDTH/BYTE_WIDTH)-1:0] i_req_wstrb,
  output logic [N_REQ-1:0]                         o_resp_valid,
  input  logic [N_REQ-1:0]                         i_resp_ready,
  output logic [N_REQ*DATA_WIDTH-1:0]              o_resp_rdata,
  output logic [N_REQ-1:0]                         o_resp_err,
  output logic                                     o_mem_we,
  output logic [XLEN-1:0]                          o_mem_addr,
  output logic [DATA_WIDTH-1:0]                    o_mem_wdata,
  output logic [(DATA_WIDTH/BYTE_WIDTH)-1:0]       o_mem_wstrb,
  input  logic [DATA_WIDTH-1:0]                    i_mem_rdata
);

  localparam int SW = DATA_WIDTH / BYTE_WIDTH;

  dmem_req_t         req [N_REQ];
  dmem_req_t         win;
  logic              win_err;
  logic [N_REQ-1:0]  slot_free;
  logic [N_REQ-1:0]  elig;
  logic [1:0]        gnt;
  logic [N_REQ-1:0]  grant;
  logic              any_gnt;
  logic              sel;

  dmem_resp_t        resp_q [N_REQ];
  dmem_resp_t        resp_d [N_REQ];
  logic [N_REQ-1:0]  resp_valid_q, resp_valid_d;

  always_comb begin
    for (int unsigned p = 0; p < N_REQ; p++) begin
      req[p].we    = i_req_we[p];
      req[p].addr  = i_req_addr[p*XLEN +: XLEN];
      req[p].wdata = i_req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
      req[p].wstrb = i_req_wstrb[p*SW +: SW];
    end
  end

  // A slot being drained this cycle can accept the next request immediately.
  assign slot_free = ~resp_valid_q | i_resp_ready;
  assign elig      = i_req_valid & slot_free;

  rr_arb2 u_rr_arb2 (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     (elig),
    .i_advance (any_gnt),
    .o_gnt     (gnt)
  );

  assign grant   = i_rst ? '0 : gnt;
  assign any_gnt = |grant;
  assign sel     = grant[1];

  always_comb begin
    win = '0;
    if (any_gnt) begin
      win = req[sel];
    end
  end

`ifdef DMEM_ARB_ADDR_CHK_EN
  assign win_err = any_gnt && req_err(win, ADDR_LIMIT);
`else
  assign win_err = 1'b0;
`endif

  always_comb begin
    o_mem_we    = win.we & ~win_err;
    o_mem_addr  = win.addr;
    o_mem_wdata = win.wdata;
    o_mem_wstrb = win_err ? '0 : win.wstrb;
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_d       = resp_q;
    for (int unsigned p = 0; p < N_REQ; p++) begin
      if (grant[p]) begin
        resp_valid_d[p]  = 1'b1;
        resp_d[p].rdata  = (win.we || win_err) ? '0 : i_mem_rdata;
        resp_d[p].err    = win_err;
      end else if (i_resp_ready[p]) begin
        resp_valid_d[p]  = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      resp_valid_q <= '0;
      for (int unsigned p = 0; p < N_REQ; p++) begin
        resp_q[p] <= '0;
      end
    end else begin
      resp_valid_q <= resp_valid_d;
      for (int unsigned p = 0; p < N_REQ; p++) begin
        resp_q[p] <= resp_d[p];
      end
    end
  end

  always_comb begin
    o_req_ready  = grant;
    o_resp_valid = resp_valid_q;
    o_resp_rdata = '0;
    o_resp_err   = '0;
    for (int unsigned p = 0; p < N_REQ; p++) begin
      o_resp_rdata[p*DATA_WIDTH +: DATA_WIDTH] = resp_q[p].rdata;
      o_resp_err[p]                            = resp_q[p].err;
    end
  end

endmodule
